// File: rtl/sprite_palette_bank_pkg.sv
// ============================================================================
// sprite_palette_bank_pkg : shared widths, types and helpers for the palette
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_palette_bank_pkg;

  localparam int INDEX_W   = 4;
  localparam int COLOR_W   = 4;
  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int FADE_W    = 4;
  localparam int LEVEL_W   = FADE_W + 1;
  localparam int ENTRIES   = 2 ** INDEX_W;
  localparam int ADDR_W    = BANK_W + INDEX_W;
  localparam int PROD_W    = COLOR_W + FADE_W + 1;

  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(2 ** FADE_W);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FADE_IN  = 2'd2
  } fade_state_t;

  // Power-up palette: entry i is the grey {i,i,i}
  function automatic rgb_t reset_entry(input logic [INDEX_W-1:0] idx);
    logic [COLOR_W-1:0] c;
    c = COLOR_W'(idx);
    return '{r: c, g: c, b: c};
  endfunction

  function automatic logic [COLOR_W-1:0] scale_chan(input logic [COLOR_W-1:0] c,
                                                     input logic [LEVEL_W-1:0] level);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(level);
    return prod[FADE_W +: COLOR_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_palette_bank_if.sv
// ============================================================================
// sprite_palette_bank_if : pixel, palette-write, bank and fade signal bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_palette_bank_if;
  import sprite_palette_bank_pkg::*;

  logic                frame_start;
  logic                pix_valid;
  logic [INDEX_W-1:0]  pix_index;
  logic                wr_en;
  logic [BANK_W-1:0]   wr_bank;
  logic [INDEX_W-1:0]  wr_index;
  rgb_t                wr_rgb;
  logic                bank_req;
  logic [BANK_W-1:0]   bank_sel;
  logic                fade_start;
  logic                fade_dir;

  logic                out_valid;
  logic [COLOR_W-1:0]  red;
  logic [COLOR_W-1:0]  green;
  logic [COLOR_W-1:0]  blue;
  logic                out_transparent;
  logic [BANK_W-1:0]   active_bank;
  logic                fade_busy;
  logic                fade_done;

  modport master (
    output frame_start, pix_valid, pix_index, wr_en, wr_bank, wr_index, wr_rgb,
           bank_req, bank_sel, fade_start, fade_dir,
    input  out_valid, red, green, blue, out_transparent, active_bank,
           fade_busy, fade_done
  );

  modport slave (
    input  frame_start, pix_valid, pix_index, wr_en, wr_bank, wr_index, wr_rgb,
           bank_req, bank_sel, fade_start, fade_dir,
    output out_valid, red, green, blue, out_transparent, active_bank,
           fade_busy, fade_done
  );

endinterface

`default_nettype wire

// File: rtl/sprite_palette_bank_fade_ctrl.sv
// ============================================================================
// sprite_palette_bank_fade_ctrl : frame-paced brightness level FSM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_palette_bank_fade_ctrl
  import sprite_palette_bank_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_frame_start,
  input  wire logic               i_fade_start,
  input  wire logic               i_fade_dir,
  output logic [LEVEL_W-1:0]      o_level,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int               CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  fade_state_t        r_state, w_state_nxt;
  logic [LEVEL_W-1:0] r_level, w_level_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               r_done,  w_done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_level <= LEVEL_FULL;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // A fade request outranks a coincident frame tick so the new fade starts with a clean count
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (i_fade_start) begin
      w_cnt_nxt = '0;
      if (i_fade_dir ? (r_level == LEVEL_FULL) : (r_level == '0)) begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = i_fade_dir ? ST_FADE_IN : ST_FADE_OUT;
      end
    end else if (i_frame_start && (r_state != ST_IDLE)) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt = '0;
        if (r_state == ST_FADE_OUT) begin
          w_level_nxt = r_level - LEVEL_W'(1);
          if (r_level == LEVEL_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_level_nxt = r_level + LEVEL_W'(1);
          if (r_level == (LEVEL_FULL - LEVEL_W'(1))) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = r_done;

endmodule

`default_nettype wire

// File: rtl/sprite_palette_bank.sv
// ============================================================================
// sprite_palette_bank : multi-bank palette lookup with frame-synced bank swap
//                       and brightness fade, 2-cycle pipelined
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_palette_bank
  import sprite_palette_bank_pkg::*;
#(
  parameter int TRANSPARENT_IDX = 0,
  parameter int FRAMES_PER_STEP = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  sprite_palette_bank_if.slave   io_bus
);

  localparam logic [INDEX_W-1:0] TRANSP_IDX = INDEX_W'(TRANSPARENT_IDX);

  rgb_t               r_pal [NUM_BANKS*ENTRIES];
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [ADDR_W-1:0]  w_rd_addr;

  logic [BANK_W-1:0]  r_active_bank;
  logic [BANK_W-1:0]  r_pend_bank;
  logic               r_pend_valid;

  logic               r_s1_valid;
  rgb_t               r_s1_rgb;
  logic               r_s1_transp;

  logic               r_out_valid;
  logic [COLOR_W-1:0] r_red, r_green, r_blue;
  logic               r_out_transp;

  logic [LEVEL_W-1:0] w_level;
  logic               w_fade_busy;
  logic               w_fade_done;

  assign w_wr_addr = {io_bus.wr_bank, io_bus.wr_index};
  assign w_rd_addr = {r_active_bank, io_bus.pix_index};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS*ENTRIES; i++) begin
        r_pal[i] <= reset_entry(i[INDEX_W-1:0]);
      end
    end else if (io_bus.wr_en) begin
      r_pal[w_wr_addr] <= io_bus.wr_rgb;
    end
  end

  // A request arriving on the frame_start cycle is applied directly, bypassing the pending slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active_bank <= '0;
      r_pend_bank   <= '0;
      r_pend_valid  <= 1'b0;
    end else if (io_bus.frame_start) begin
      r_pend_valid <= 1'b0;
      if (io_bus.bank_req) begin
        r_active_bank <= io_bus.bank_sel;
      end else if (r_pend_valid) begin
        r_active_bank <= r_pend_bank;
      end
    end else if (io_bus.bank_req) begin
      r_pend_bank  <= io_bus.bank_sel;
      r_pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_rgb    <= '0;
      r_s1_transp <= 1'b0;
    end else begin
      r_s1_valid <= io_bus.pix_valid;
      if (io_bus.pix_valid) begin
        r_s1_rgb    <= r_pal[w_rd_addr];
        r_s1_transp <= (io_bus.pix_index == TRANSP_IDX);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
      r_out_transp <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_red        <= scale_chan(r_s1_rgb.r, w_level);
        r_green      <= scale_chan(r_s1_rgb.g, w_level);
        r_blue       <= scale_chan(r_s1_rgb.b, w_level);
        r_out_transp <= r_s1_transp;
      end
    end
  end

  sprite_palette_bank_fade_ctrl #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_fade_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (io_bus.frame_start),
    .i_fade_start  (io_bus.fade_start),
    .i_fade_dir    (io_bus.fade_dir),
    .o_level       (w_level),
    .o_busy        (w_fade_busy),
    .o_done        (w_fade_done)
  );

  assign io_bus.out_valid       = r_out_valid;
  assign io_bus.red             = r_red;
  assign io_bus.green           = r_green;
  assign io_bus.blue            = r_blue;
  assign io_bus.out_transparent = r_out_transp;
  assign io_bus.active_bank     = r_active_bank;
  assign io_bus.fade_busy       = w_fade_busy;
  assign io_bus.fade_done       = w_fade_done;

endmodule

`default_nettype wire

// File: tb/tb_sprite_palette_bank.sv
// ============================================================================
// tb_sprite_palette_bank : directed self-checking bench for sprite_palette_bank
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_palette_bank;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  sprite_palette_bank_if bus_if ();

  sprite_palette_bank #(
    .TRANSPARENT_IDX (0),
    .FRAMES_PER_STEP (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] rgb_out();
    return {bus_if.red, bus_if.green, bus_if.blue};
  endfunction

  task automatic look(input string tag, input logic [3:0] idx,
                      input logic [11:0] exp_rgb, input logic exp_tr);
    bus_if.pix_valid = 1'b1;
    bus_if.pix_index = idx;
    tick();
    bus_if.pix_valid = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    check({tag, "_rgb"},   32'(rgb_out()),        32'(exp_rgb));
    check({tag, "_tr"},    32'(bus_if.out_transparent), 32'(exp_tr));
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      bus_if.frame_start = 1'b1;
      tick();
      bus_if.frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic fade(input logic dir);
    bus_if.fade_start = 1'b1;
    bus_if.fade_dir   = dir;
    tick();
    bus_if.fade_start = 1'b0;
  endtask

  task automatic bank_now(input logic [1:0] b);
    bus_if.bank_req    = 1'b1;
    bus_if.bank_sel    = b;
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.bank_req    = 1'b0;
    bus_if.frame_start = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus_if.frame_start = 1'b0;
    bus_if.pix_valid   = 1'b0;
    bus_if.pix_index   = '0;
    bus_if.wr_en       = 1'b0;
    bus_if.wr_bank     = '0;
    bus_if.wr_index    = '0;
    bus_if.wr_rgb      = '0;
    bus_if.bank_req    = 1'b0;
    bus_if.bank_sel    = '0;
    bus_if.fade_start  = 1'b0;
    bus_if.fade_dir    = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_rgb",   32'(rgb_out()), 32'd0);
    check("rst_tr",    32'(bus_if.out_transparent), 32'd0);
    check("rst_bank",  32'(bus_if.active_bank), 32'd0);
    check("rst_busy",  32'(bus_if.fade_busy), 32'd0);
    check("rst_done",  32'(bus_if.fade_done), 32'd0);
    rst = 1'b0;
    tick();

    // Latency and hold behaviour on index 5
    bus_if.pix_valid = 1'b1;
    bus_if.pix_index = 4'd5;
    tick();
    bus_if.pix_valid = 1'b0;
    check("lat1_valid", 32'(bus_if.out_valid), 32'd0);
    tick();
    check("lat2_valid", 32'(bus_if.out_valid), 32'd1);
    check("idx5_rgb",   32'(rgb_out()), 32'h555);
    check("idx5_tr",    32'(bus_if.out_transparent), 32'd0);
    tick();
    check("hold_valid", 32'(bus_if.out_valid), 32'd0);
    check("hold_rgb",   32'(rgb_out()), 32'h555);

    look("idx0", 4'd0, 12'h000, 1'b1);
    look("idx15", 4'd15, 12'hFFF, 1'b0);

    // Bank switching
    bus_if.bank_req = 1'b1;
    bus_if.bank_sel = 2'd2;
    tick();
    bus_if.bank_req = 1'b0;
    check("bank_pend0", 32'(bus_if.active_bank), 32'd0);
    tick();
    tick();
    check("bank_pend1", 32'(bus_if.active_bank), 32'd0);
    frames(1);
    check("bank_sw2", 32'(bus_if.active_bank), 32'd2);
    bus_if.bank_req = 1'b1;
    bus_if.bank_sel = 2'd1;
    tick();
    bus_if.bank_sel = 2'd3;
    tick();
    bus_if.bank_req = 1'b0;
    check("bank_hold2", 32'(bus_if.active_bank), 32'd2);
    frames(1);
    check("bank_last3", 32'(bus_if.active_bank), 32'd3);
    frames(1);
    check("bank_noreq", 32'(bus_if.active_bank), 32'd3);
    bank_now(2'd1);
    check("bank_coinc1", 32'(bus_if.active_bank), 32'd1);

    // Write with same-cycle lookup of that entry, then lookup next cycle
    bus_if.wr_en     = 1'b1;
    bus_if.wr_bank   = 2'd1;
    bus_if.wr_index  = 4'd3;
    bus_if.wr_rgb    = 12'hFC7;
    bus_if.pix_valid = 1'b1;
    bus_if.pix_index = 4'd3;
    tick();
    bus_if.wr_en = 1'b0;
    tick();
    bus_if.pix_valid = 1'b0;
    check("wr_old_rgb", 32'(rgb_out()), 32'h333);
    tick();
    check("wr_new_valid", 32'(bus_if.out_valid), 32'd1);
    check("wr_new_rgb",   32'(rgb_out()), 32'hFC7);

    // Fade out 16 -> 10, then reverse 10 -> 16
    fade(1'b0);
    check("fo_busy", 32'(bus_if.fade_busy), 32'd1);
    frames(1);
    look("fo_f1", 4'd15, 12'hFFF, 1'b0);
    frames(11);
    look("fo_lvl10", 4'd15, 12'h999, 1'b0);
    fade(1'b1);
    frames(11);
    look("fi_lvl15", 4'd15, 12'hEEE, 1'b0);
    check("fi_busy", 32'(bus_if.fade_busy), 32'd1);
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.frame_start = 1'b0;
    check("fi_done", 32'(bus_if.fade_done), 32'd1);
    check("fi_idle", 32'(bus_if.fade_busy), 32'd0);
    tick();
    check("fi_done_pulse", 32'(bus_if.fade_done), 32'd0);
    look("fi_full", 4'd15, 12'hFFF, 1'b0);

    // Fade-in requested when already full
    fade(1'b1);
    check("at_tgt_done", 32'(bus_if.fade_done), 32'd1);
    check("at_tgt_busy", 32'(bus_if.fade_busy), 32'd0);
    tick();
    check("at_tgt_pulse", 32'(bus_if.fade_done), 32'd0);

    // Full fade to black over 32 frames
    fade(1'b0);
    frames(16);
    look("fo_lvl8", 4'd15, 12'h777, 1'b0);
    frames(15);
    check("fo31_done", 32'(bus_if.fade_done), 32'd0);
    check("fo31_busy", 32'(bus_if.fade_busy), 32'd1);
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.frame_start = 1'b0;
    check("fo32_done", 32'(bus_if.fade_done), 32'd1);
    check("fo32_busy", 32'(bus_if.fade_busy), 32'd0);
    tick();
    check("fo32_pulse", 32'(bus_if.fade_done), 32'd0);
    look("fo_black", 4'd15, 12'h000, 1'b0);
    look("fo_black_tr", 4'd0, 12'h000, 1'b1);

    // Fade start coincident with frame_start: counter restarts from zero
    bus_if.fade_start  = 1'b1;
    bus_if.fade_dir    = 1'b1;
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.fade_start  = 1'b0;
    bus_if.frame_start = 1'b0;
    tick();
    frames(3);
    look("coinc_lvl1", 4'd15, 12'h000, 1'b0);
    frames(1);
    look("coinc_lvl2", 4'd15, 12'h111, 1'b0);

    // Reset in the middle of a fade with pixels streaming
    bus_if.pix_valid = 1'b1;
    bus_if.pix_index = 4'd15;
    tick();
    tick();
    tick();
    check("pre_rst_valid", 32'(bus_if.out_valid), 32'd1);
    check("pre_rst_busy",  32'(bus_if.fade_busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("mid_rst_rgb",   32'(rgb_out()), 32'd0);
    check("mid_rst_busy",  32'(bus_if.fade_busy), 32'd0);
    check("mid_rst_bank",  32'(bus_if.active_bank), 32'd0);
    bus_if.pix_valid = 1'b0;
    rst = 1'b0;
    tick();
    look("post_rst_full", 4'd15, 12'hFFF, 1'b0);
    bank_now(2'd1);
    look("post_rst_pal", 4'd3, 12'h333, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
